// File: rtl/seq_divider.sv
// Restoring radix-2 sequential divider, one quotient bit per clock.
// SEQ_DIVIDER_FAST_SPECIAL_EN: divide-by-zero / signed overflow skip CALC.
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_signed,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder,
    output logic             o_div_zero
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIXUP,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dsr;
    logic [CW-1:0]    cnt;
    logic             q_neg;
    logic             r_neg;
    logic             dz;

    logic             a_neg;
    logic             b_neg;
    logic             b_zero;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   trial;

    assign a_neg  = i_signed & i_dividend[WIDTH-1];
    assign b_neg  = i_signed & i_divisor[WIDTH-1];
    assign b_zero = (i_divisor == '0);
    assign abs_a  = a_neg ? -i_dividend : i_dividend;
    assign abs_b  = b_neg ? -i_divisor : i_divisor;

    // Remainder stays below the divisor, so WIDTH bits hold it between steps
    assign rem_sh = {rem, dvd[WIDTH-1]};
    assign trial  = rem_sh - {1'b0, dsr};

`ifdef SEQ_DIVIDER_FAST_SPECIAL_EN
    logic ovf;
    assign ovf = i_signed
               & (i_dividend == {1'b1, {(WIDTH-1){1'b0}}})
               & (&i_divisor);
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            rem         <= '0;
            dvd         <= '0;
            dsr         <= '0;
            cnt         <= '0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            dz          <= 1'b0;
            o_ready     <= 1'b1;
            o_valid     <= 1'b0;
            o_quotient  <= '0;
            o_remainder <= '0;
            o_div_zero  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (i_start) begin
                        dvd     <= abs_a;
                        dsr     <= abs_b;
                        rem     <= '0;
                        cnt     <= CW'(WIDTH-1);
                        q_neg   <= a_neg ^ b_neg;
                        r_neg   <= a_neg;
                        dz      <= b_zero;
                        o_ready <= 1'b0;
`ifdef SEQ_DIVIDER_FAST_SPECIAL_EN
                        if (b_zero | ovf) begin
                            o_quotient  <= b_zero ? '1 : i_dividend;
                            o_remainder <= b_zero ? i_dividend : '0;
                            o_div_zero  <= b_zero;
                            o_valid     <= 1'b1;
                            state       <= DONE;
                        end else begin
                            state <= CALC;
                        end
`else
                        state <= CALC;
`endif
                    end
                end
                CALC: begin
                    rem <= trial[WIDTH] ? rem_sh[WIDTH-1:0]
                                        : trial[WIDTH-1:0];
                    dvd <= {dvd[WIDTH-2:0], ~trial[WIDTH]};
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) begin
                        state <= FIXUP;
                    end
                end
                FIXUP: begin
                    // Negating |rem| restores the original dividend when dz
                    o_quotient  <= dz ? '1 : (q_neg ? -dvd : dvd);
                    o_remainder <= r_neg ? -rem : rem;
                    o_div_zero  <= dz;
                    o_valid     <= 1'b1;
                    state       <= DONE;
                end
                DONE: begin
                    o_valid <= 1'b0;
                    o_ready <= 1'b1;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Directed-vector bench for seq_divider (WIDTH=32).
// Latency expectations follow SEQ_DIVIDER_FAST_SPECIAL_EN.
module tb_seq_divider;

`ifdef SEQ_DIVIDER_FAST_SPECIAL_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    localparam int NLAT = 33;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_start;
    logic        i_signed;
    logic [31:0] i_dividend;
    logic [31:0] i_divisor;
    logic        o_ready;
    logic        o_valid;
    logic [31:0] o_quotient;
    logic [31:0] o_remainder;
    logic        o_div_zero;

    int nvec = 0;
    int nmis = 0;

    seq_divider #(.WIDTH(32)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_start     (i_start),
        .i_signed    (i_signed),
        .i_dividend  (i_dividend),
        .i_divisor   (i_divisor),
        .o_ready     (o_ready),
        .o_valid     (o_valid),
        .o_quotient  (o_quotient),
        .o_remainder (o_remainder),
        .o_div_zero  (o_div_zero)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        logic        sp;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic start_op(input logic sgn, input logic [31:0] a,
                            input logic [31:0] b);
        int n;
        n = 0;
        while (!o_ready && n < 100) begin
            @(posedge i_clk);
            #1;
            n++;
        end
        chk("ready_before_start", {31'd0, o_ready}, 32'd1);
        i_start    = 1'b1;
        i_signed   = sgn;
        i_dividend = a;
        i_divisor  = b;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
    endtask

    task automatic wait_res(input string tag, input int n0,
                            input logic [31:0] q, input logic [31:0] r,
                            input logic dz, input int lat);
        int n;
        n = n0;
        while (!o_valid && n < 100) begin
            @(posedge i_clk);
            #1;
            n++;
        end
        chk({tag, ".lat"}, n, lat);
        chk({tag, ".q"}, o_quotient, q);
        chk({tag, ".r"}, o_remainder, r);
        chk({tag, ".dz"}, {31'd0, o_div_zero}, {31'd0, dz});
        chk({tag, ".rdy_busy"}, {31'd0, o_ready}, 32'd0);
        @(posedge i_clk);
        #1;
        chk({tag, ".pulse"}, {31'd0, o_valid}, 32'd0);
        chk({tag, ".rdy"}, {31'd0, o_ready}, 32'd1);
    endtask

    initial begin
        logic seen;

        tbl[0]  = '{1'b0, 32'd100,        32'd7,        32'd14,
                    32'd2,        1'b0, 1'b0};
        tbl[1]  = '{1'b1, 32'hFFFF_FFF9,  32'd2,        32'hFFFF_FFFD,
                    32'hFFFF_FFFF, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD,
                    32'd1,        1'b0, 1'b0};
        tbl[3]  = '{1'b0, 32'hFFFF_FFFF,  32'd2,        32'h7FFF_FFFF,
                    32'd1,        1'b0, 1'b0};
        tbl[4]  = '{1'b0, 32'd5,          32'd0,        32'hFFFF_FFFF,
                    32'd5,        1'b1, 1'b1};
        tbl[5]  = '{1'b1, 32'd5,          32'd0,        32'hFFFF_FFFF,
                    32'd5,        1'b1, 1'b1};
        tbl[6]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000,
                    32'd0,        1'b0, 1'b1};
        tbl[7]  = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,
                    32'h8000_0000, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 32'hFFFF_FF9C,  32'd7,        32'hFFFF_FFF2,
                    32'hFFFF_FFFE, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 32'hFFFF_FFFB,  32'd0,        32'hFFFF_FFFF,
                    32'hFFFF_FFFB, 1'b1, 1'b1};
        tbl[10] = '{1'b0, 32'd0,          32'd3,        32'd0,
                    32'd0,        1'b0, 1'b0};
        tbl[11] = '{1'b0, 32'd3,          32'd5,        32'd0,
                    32'd3,        1'b0, 1'b0};

        i_rst_n    = 1'b0;
        i_start    = 1'b0;
        i_signed   = 1'b0;
        i_dividend = '0;
        i_divisor  = '0;
        repeat (2) @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        chk("rst.ready", {31'd0, o_ready}, 32'd1);
        chk("rst.valid", {31'd0, o_valid}, 32'd0);
        chk("rst.q", o_quotient, 32'd0);
        chk("rst.r", o_remainder, 32'd0);
        chk("rst.dz", {31'd0, o_div_zero}, 32'd0);

        // Back-to-back: each start lands on the first o_ready cycle
        for (int i = 0; i < 12; i++) begin
            start_op(tbl[i].sgn, tbl[i].a, tbl[i].b);
            wait_res($sformatf("vec%0d", i), 0, tbl[i].q, tbl[i].r,
                     tbl[i].dz, (FAST && tbl[i].sp) ? 0 : NLAT);
        end

        // Request while busy must be ignored
        start_op(1'b0, 32'd100, 32'd7);
        repeat (4) @(posedge i_clk);
        #1;
        i_start    = 1'b1;
        i_dividend = 32'd9;
        i_divisor  = 32'd3;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        wait_res("busy_start", 5, 32'd14, 32'd2, 1'b0, NLAT);

        // Reset mid-operation aborts with no result
        start_op(1'b0, 32'd100, 32'd7);
        repeat (9) @(posedge i_clk);
        #1;
        i_rst_n = 1'b0;
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        chk("abort.ready", {31'd0, o_ready}, 32'd1);
        chk("abort.valid", {31'd0, o_valid}, 32'd0);
        chk("abort.q", o_quotient, 32'd0);
        chk("abort.r", o_remainder, 32'd0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge i_clk);
            #1;
            seen = seen | o_valid;
        end
        chk("abort.no_valid", {31'd0, seen}, 32'd0);

        start_op(1'b0, 32'd81, 32'd9);
        wait_res("after_abort", 0, 32'd9, 32'd0, 1'b0, NLAT);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
